// File: rtl/defog_pkg.sv
// Shared types, widths and arithmetic helpers for the defog recovery pipeline.
package defog_pkg;

  localparam int PIPE_LAT = 5;
  localparam int PIX_W    = 8;
  localparam int RECIP_W  = 16;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  // floor(65535/x), saturating at x == 0
  function automatic logic [RECIP_W-1:0] recip(input logic [PIX_W-1:0] x);
    logic [RECIP_W-1:0] res;
    if (x == 8'd0) res = 16'hFFFF;
    else           res = 16'(32'd65535 / {24'd0, x});
    return res;
  endfunction

  function automatic logic signed [17:0] scale_diff(input logic [PIX_W-1:0] pix,
                                                    input logic [PIX_W-1:0] a,
                                                    input logic [RECIP_W-1:0] rcp);
    logic signed [8:0]  diff;
    logic signed [25:0] prod;
    diff = $signed({1'b0, pix}) - $signed({1'b0, a});
    prod = 26'(diff) * $signed({10'd0, rcp});
    return 18'(prod >>> 8);
  endfunction

  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [18:0] v);
    logic [PIX_W-1:0] res;
    if (v < 19'sd0)        res = 8'd0;
    else if (v > 19'sd255) res = 8'd255;
    else                   res = v[7:0];
    return res;
  endfunction

endpackage

// File: rtl/defog_recover_if.sv
// Video stream bundle for defog_recover: hazy pixel + dark channel in, recovered pixel out.
interface defog_recover_if;
  import defog_pkg::*;

  logic [3*PIX_W-1:0] i_rgb;
  logic [PIX_W-1:0]   i_dark;
  logic               i_hsync;
  logic               i_vsync;
  logic               i_de;
  logic [3*PIX_W-1:0] o_rgb;
  logic               o_hsync;
  logic               o_vsync;
  logic               o_de;
  logic [PIX_W-1:0]   o_a;

  modport master (
    output i_rgb, i_dark, i_hsync, i_vsync, i_de,
    input  o_rgb, o_hsync, o_vsync, o_de, o_a
  );

  modport slave (
    input  i_rgb, i_dark, i_hsync, i_vsync, i_de,
    output o_rgb, o_hsync, o_vsync, o_de, o_a
  );
endinterface

// File: rtl/defog_recip_lut.sv
// Registered 256x16 reciprocal ROM; RST_VAL sets the output register value under reset.
module defog_recip_lut
  import defog_pkg::*;
#(
  parameter logic [RECIP_W-1:0] RST_VAL = 16'd0
) (
  input  logic               pixelclk,
  input  logic               reset_n,
  input  logic [PIX_W-1:0]   addr,
  output logic [RECIP_W-1:0] data
);

  logic [RECIP_W-1:0] rom [256];
  logic [RECIP_W-1:0] data_d;
  logic [RECIP_W-1:0] data_q;

  // Constant per-entry division folds into a plain lookup table.
  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign rom[gi] = recip(8'(gi));
  end

  always_comb begin
    data_d = rom[addr];
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) data_q <= RST_VAL;
    else          data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/defog_recover.sv
// Dark-channel-prior haze removal: 5-stage pipeline recovering J = A + (I - A)/t.
// Build option: DEFOG_A_IIR_EN smooths the per-frame atmospheric light update.
module defog_recover
  import defog_pkg::*;
#(
  parameter int unsigned OMEGA  = 243,
  parameter int unsigned T_MIN  = 26,
  parameter int unsigned A_INIT = 255
) (
  input logic            pixelclk,
  input logic            reset_n,
  defog_recover_if.slave vid
);

  localparam logic [PIX_W-1:0] OMEGA_B  = 8'(OMEGA);
  localparam logic [PIX_W-1:0] T_MIN_B  = 8'(T_MIN);
  localparam logic [PIX_W-1:0] A_INIT_B = 8'(A_INIT);

  typedef struct packed {
    logic [15:0]      ratio_raw;
    rgb_t             pix;
    logic [PIX_W-1:0] a;
  } s1_t;

  typedef struct packed {
    logic [PIX_W-1:0] t_raw;
    rgb_t             pix;
    logic [PIX_W-1:0] a;
  } s2_t;

  typedef struct packed {
    rgb_t             pix;
    logic [PIX_W-1:0] a;
  } s3_t;

  typedef struct packed {
    logic signed [17:0] sr;
    logic signed [17:0] sg;
    logic signed [17:0] sb;
    logic [PIX_W-1:0]   a;
  } s4_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  rgb_t s5_d, s5_q;
  sync_t sync_d [PIPE_LAT];
  sync_t sync_q [PIPE_LAT];

  logic [PIX_W-1:0]   a_d, a_q;
  logic [PIX_W-1:0]   fmax_d, fmax_q;
  logic               vs_prev_d, vs_prev_q;
  logic [PIX_W-1:0]   fmax_upd;
  logic [PIX_W-1:0]   t_clamped;
  logic [PIX_W-1:0]   ratio;
  logic [15:0]        omega_prod;
  logic [RECIP_W-1:0] recip_a;
  logic [RECIP_W-1:0] recip_t;

  defog_recip_lut #(.RST_VAL(recip(A_INIT_B))) u_recip_a (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .addr     (a_q),
    .data     (recip_a)
  );

  // The ROM output register doubles as the S3 recip(t) stage.
  defog_recip_lut #(.RST_VAL(16'd0)) u_recip_t (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .addr     (t_clamped),
    .data     (recip_t)
  );

  // Next-state for frame max, atmospheric light and all pipeline stages.
  always_comb begin
    if (vid.i_de && (vid.i_dark > fmax_q)) fmax_upd = vid.i_dark;
    else                                   fmax_upd = fmax_q;

    vs_prev_d = vid.i_vsync;
    a_d       = a_q;
    fmax_d    = fmax_upd;
    if (vid.i_vsync && !vs_prev_q) begin
      fmax_d = 8'd0;
      if (fmax_upd != 8'd0) begin
`ifdef DEFOG_A_IIR_EN
        a_d = 8'((10'd3 * {2'b00, a_q} + {2'b00, fmax_upd}) >> 2);
`else
        a_d = fmax_upd;
`endif
      end else begin
        a_d = a_q;
      end
    end else begin
      fmax_d = fmax_upd;
    end

    s1_d.ratio_raw = 16'((24'(vid.i_dark) * 24'(recip_a)) >> 8);
    s1_d.pix       = rgb_t'(vid.i_rgb);
    s1_d.a         = a_q;

    if (s1_q.ratio_raw > 16'd255) ratio = 8'd255;
    else                          ratio = s1_q.ratio_raw[7:0];
    omega_prod  = 16'(OMEGA_B) * 16'(ratio);
    s2_d.t_raw  = 8'd255 - omega_prod[15:8];
    s2_d.pix    = s1_q.pix;
    s2_d.a      = s1_q.a;

    if (s2_q.t_raw < T_MIN_B) t_clamped = T_MIN_B;
    else                      t_clamped = s2_q.t_raw;
    s3_d.pix = s2_q.pix;
    s3_d.a   = s2_q.a;

    s4_d.sr = scale_diff(s3_q.pix.r, s3_q.a, recip_t);
    s4_d.sg = scale_diff(s3_q.pix.g, s3_q.a, recip_t);
    s4_d.sb = scale_diff(s3_q.pix.b, s3_q.a, recip_t);
    s4_d.a  = s3_q.a;

    // Blanking pixels are forced to black at the output.
    if (sync_q[PIPE_LAT-2].de) begin
      s5_d.r = clamp_u8(19'($signed({1'b0, s4_q.a})) + 19'(s4_q.sr));
      s5_d.g = clamp_u8(19'($signed({1'b0, s4_q.a})) + 19'(s4_q.sg));
      s5_d.b = clamp_u8(19'($signed({1'b0, s4_q.a})) + 19'(s4_q.sb));
    end else begin
      s5_d = '{r: 8'd0, g: 8'd0, b: 8'd0};
    end

    sync_d[0] = '{hsync: vid.i_hsync, vsync: vid.i_vsync, de: vid.i_de};
    for (int i = 1; i < PIPE_LAT; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // State and pipeline registers.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= A_INIT_B;
      fmax_q    <= 8'd0;
      vs_prev_q <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      s4_q      <= '0;
      s5_q      <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      a_q       <= a_d;
      fmax_q    <= fmax_d;
      vs_prev_q <= vs_prev_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      s4_q      <= s4_d;
      s5_q      <= s5_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign vid.o_rgb   = s5_q;
  assign vid.o_hsync = sync_q[PIPE_LAT-1].hsync;
  assign vid.o_vsync = sync_q[PIPE_LAT-1].vsync;
  assign vid.o_de    = sync_q[PIPE_LAT-1].de;
  assign vid.o_a     = a_q;

endmodule

// File: tb/tb_defog_recover.sv
// Self-checking bench for defog_recover: directed cases plus random frames against an integer model.
module tb_defog_recover;
  import defog_pkg::*;

  localparam int OMEGA  = 243;
  localparam int T_MIN  = 26;
  localparam int A_INIT = 255;
`ifdef DEFOG_A_IIR_EN
  localparam bit IIR = 1'b1;
`else
  localparam bit IIR = 1'b0;
`endif

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;
  defog_recover_if vid();

  defog_recover #(.OMEGA(OMEGA), .T_MIN(T_MIN), .A_INIT(A_INIT)) dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .vid      (vid)
  );

  always #5 pixelclk = ~pixelclk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_a    = A_INIT;
  int   m_fmax = 0;
  bit   m_prev_vs = 1'b0;

  function automatic int recip_m(int x);
    return (x == 0) ? 65535 : 65535 / x;
  endfunction

  function automatic int chan_m(int c, int a, int rt);
    int j;
    j = a + (((c - a) * rt) >>> 8);
    if (j < 0) j = 0;
    if (j > 255) j = 255;
    return j;
  endfunction

  // J = A + (I - A) / max(T_MIN, 1 - w*dark/A), all in fixed point
  function automatic logic [23:0] model_px(logic [23:0] rgb, int dark, int a);
    int ratio, t, rt, jr, jg, jb;
    ratio = (dark * recip_m(a)) / 256;
    if (ratio > 255) ratio = 255;
    t = 255 - (OMEGA * ratio) / 256;
    if (t < T_MIN) t = T_MIN;
    rt = recip_m(t);
    jr = chan_m(int'(rgb[23:16]), a, rt);
    jg = chan_m(int'(rgb[15:8]),  a, rt);
    jb = chan_m(int'(rgb[7:0]),   a, rt);
    return {8'(jr), 8'(jg), 8'(jb)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    for (int i = 0; i < PIPE_LAT - 1; i++) exp_q.push_back('{24'h0, 1'b0, 1'b0, 1'b0});
    m_a       = A_INIT;
    m_fmax    = 0;
    m_prev_vs = 1'b0;
  endtask

  // Drive one cycle of input, advance the model, then check the outputs after the edge.
  task automatic drive(input logic [23:0] rgb, input int dark, input logic hs, input logic vs,
                       input logic de, input bit use_c, input logic [23:0] c_rgb);
    exp_t e;
    vid.i_rgb   = rgb;
    vid.i_dark  = 8'(dark);
    vid.i_hsync = hs;
    vid.i_vsync = vs;
    vid.i_de    = de;
    e.rgb = de ? (use_c ? c_rgb : model_px(rgb, dark, m_a)) : 24'h0;
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    exp_q.push_back(e);
    if (de && dark > m_fmax) m_fmax = dark;
    if (vs && !m_prev_vs) begin
      if (m_fmax != 0) m_a = IIR ? (3 * m_a + m_fmax) / 4 : m_fmax;
      m_fmax = 0;
    end
    m_prev_vs = vs;
    @(posedge pixelclk);
    #1;
    e = exp_q.pop_front();
    check("o_rgb",   32'(vid.o_rgb),   32'(e.rgb));
    check("o_hsync", 32'(vid.o_hsync), 32'(e.hs));
    check("o_vsync", 32'(vid.o_vsync), 32'(e.vs));
    check("o_de",    32'(vid.o_de),    32'(e.de));
    check("o_a",     32'(vid.o_a),     32'(m_a));
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) drive(24'h0, 0, 1'b0, vs, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, 32'(vid.o_rgb),   32'h0);
    check({tag, "_hs"},  32'(vid.o_hsync), 32'h0);
    check({tag, "_vs"},  32'(vid.o_vsync), 32'h0);
    check({tag, "_de"},  32'(vid.o_de),    32'h0);
    check({tag, "_a"},   32'(vid.o_a),     32'(A_INIT));
  endtask

  initial begin
    int lim, npix;
    vid.i_rgb = 24'h0; vid.i_dark = 8'h0;
    vid.i_hsync = 1'b0; vid.i_vsync = 1'b0; vid.i_de = 1'b0;
    reset_model();
    repeat (2) @(posedge pixelclk);
    #1;
    check_reset_outputs("rst");
    @(negedge pixelclk);
    reset_n = 1'b1;

    // A = 255, dark = 0: t = 255, recip = 257
    drive(24'h6496C8, 0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h6395C7);
    drive(24'h123456, 50, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    drive(24'hABCDEF, 90, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
    // Max dark pixel arrives on the vsync rising cycle itself
    drive(24'h808080, 180, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
    check("a_after_180", 32'(vid.o_a), IIR ? 32'd236 : 32'd180);
    idle(1, 1'b1);
    idle(6, 1'b0);

    // Empty frame leaves A unchanged
    idle(2, 1'b1);
    check("a_empty_hold", 32'(vid.o_a), IIR ? 32'd236 : 32'd180);
    idle(3, 1'b0);

    // Frame with max dark 200
    drive(24'h405060, 120, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    drive(24'hC0B0A0, 200, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    // A = 200, dark = 200: t clamps to T_MIN, recip = 2520
    drive(24'hD2C8BE, 200, 1'b0, 1'b0, 1'b1, !IIR, 24'hFFC865);
    idle(6, 1'b0);

    // Random frames, with a mid-frame reset in frame 3
    for (int f = 0; f < 6; f++) begin
      lim  = $urandom_range(30, 255);
      npix = $urandom_range(30, 50);
      idle(2, 1'b1);
      idle(2, 1'b0);
      for (int p = 0; p < npix; p++) begin
        drive(24'($urandom), $urandom_range(0, lim), 1'($urandom_range(0, 1)), 1'b0,
              ($urandom_range(0, 7) != 0), 1'b0, 24'h0);
        if (f == 3 && p == 20) begin
          reset_n = 1'b0;
          #1;
          check_reset_outputs("mid_rst");
          reset_model();
          @(negedge pixelclk);
          reset_n = 1'b1;
        end
      end
      idle(2, 1'b0);
    end
    idle(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
